// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
// One external hex decoder is shared by all digits: the controller presents one
// nibble at a time, then registers the decoder result with the decimal point.
// The displayed value is double-buffered and only committed at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS           = 4,
  parameter int unsigned PRESCALE         = 50000,
  parameter int unsigned BLANK_CYCLES     = 16,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic                lz_suppress,
  output logic [3:0]          dec_nibble,
  input  logic [7:0]          dec_seg,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   an,
  output logic                frame_start
);

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = $clog2(DIGITS);

  // Anode vector with every digit dark; XOR with a one-hot gives the lit pattern.
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ANODE_ACTIVE_LOW}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [IDX_W-1:0]              idx, idx_nxt;
  logic [SEG_W-1:0]              seg_nxt;
  logic [DIGITS-1:0]             an_nxt;
  logic                          frame_start_nxt;

  logic [DIGITS-1:0][NIB_W-1:0]  active_val, shadow_val;
  logic [DIGITS-1:0]             active_dp, shadow_dp;
  logic                          pending;

  logic [DIGITS-1:0]             upper_zero;
  logic [DIGITS-1:0]             an_onehot;
  logic                          suppress;
  logic                          blank_done;
  logic                          show_done;
  logic                          idx_last;
  logic                          frame_edge;

  // Decoder bit 7 is defined as don't-care.
  logic unused_dec_bit7;
  assign unused_dec_bit7 = dec_seg[7];

  // The decoder always sees the active nibble of the digit being scanned.
  assign dec_nibble = active_val[idx];

  // upper_zero[i] is set when active nibbles DIGITS-1 down to i are all zero.
  always_comb begin : lz_scan
    logic all_zero;
    all_zero   = 1'b1;
    upper_zero = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero      = all_zero & (active_val[i] == '0);
      upper_zero[i] = all_zero;
    end
  end

  // Scan-position decode shared by the FSM and the buffer commit logic.
  always_comb begin
    suppress   = lz_suppress && (idx != '0) && upper_zero[idx];
    an_onehot  = DIGITS'(1) << idx;
    blank_done = (state == ST_BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
    show_done  = (state == ST_SHOW)  && (cnt == CNT_W'(PRESCALE - 1));
    idx_last   = (idx == IDX_W'(DIGITS - 1));
    frame_edge = show_done && idx_last;
  end

  // Next-state and next-output logic for the blank/show scan sequence.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + CNT_W'(1);
    idx_nxt         = idx;
    seg_nxt         = seg_out;
    an_nxt          = an;
    frame_start_nxt = 1'b0;

    case (state)
      ST_BLANK: begin
        seg_nxt = '0;
        an_nxt  = AN_OFF;
        if (blank_done) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
          an_nxt    = an_onehot ^ AN_OFF;
          seg_nxt   = {active_dp[idx], suppress ? 7'b0 : dec_seg[6:0]};
        end
      end
      ST_SHOW: begin
        if (show_done) begin
          state_nxt       = ST_BLANK;
          cnt_nxt         = '0;
          an_nxt          = AN_OFF;
          seg_nxt         = '0;
          idx_nxt         = idx_last ? '0 : idx + IDX_W'(1);
          frame_start_nxt = idx_last;
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        seg_nxt   = '0;
        an_nxt    = AN_OFF;
      end
    endcase
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      seg_out     <= '0;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      seg_out     <= seg_nxt;
      an          <= an_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // Double buffer: loads land in shadow, committed to active only at frame edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_val <= '0;
      active_dp  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (frame_edge) begin
      pending <= 1'b0;
      if (load) begin
        active_val <= value;
        active_dp  <= dp_mask;
      end else if (pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_mask;
      pending    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed steps followed by random loads,
// checked every cycle against a frame/slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT = PRESCALE + BLANK_CYCLES;
  localparam int FRAME = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_suppress;
  logic [3:0]  dec_nibble;
  logic [7:0]  dec_seg;
  logic [7:0]  seg_out;
  logic [3:0]  an;
  logic        frame_start;
  logic        junk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  int          c;
  logic [15:0] disp, shadow;
  logic [3:0]  disp_dp, shadow_dp;
  bit          pending;
  logic [7:0]  exp_seg;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(DIGITS),
    .PRESCALE(PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .value(value),
    .dp_mask(dp_mask),
    .lz_suppress(lz_suppress),
    .dec_nibble(dec_nibble),
    .dec_seg(dec_seg),
    .seg_out(seg_out),
    .an(an),
    .frame_start(frame_start)
  );

  // External hex decoder: a=bit6 .. g=bit0, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h7E; 4'h1: hex7 = 7'h30; 4'h2: hex7 = 7'h6D; 4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33; 4'h5: hex7 = 7'h5B; 4'h6: hex7 = 7'h5F; 4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h7B; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E; 4'hD: hex7 = 7'h3D; 4'hE: hex7 = 7'h4F; default: hex7 = 7'h47;
    endcase
  endfunction

  assign dec_seg = {junk, hex7(dec_nibble)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    c = 0;
    disp = '0;
    disp_dp = '0;
    shadow = '0;
    shadow_dp = '0;
    pending = 1'b0;
    exp_seg = '0;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  function automatic void model_edge();
    int d;
    bit sup;
    if ((c + 1) % FRAME == 0) begin
      if (load) begin
        disp = value;
        disp_dp = dp_mask;
      end else if (pending) begin
        disp = shadow;
        disp_dp = shadow_dp;
      end
      pending = 1'b0;
    end else if (load) begin
      shadow = value;
      shadow_dp = dp_mask;
      pending = 1'b1;
    end
    c = c + 1;
    if (c % SLOT == BLANK_CYCLES) begin
      d = (c % FRAME) / SLOT;
      sup = lz_suppress && (d > 0) && ((disp >> (4 * d)) == 16'h0);
      exp_seg = {disp_dp[d], sup ? 7'h00 : hex7(disp[4*d +: 4])};
    end
  endfunction

  task automatic check_all();
    int f, d, s;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    f = c % FRAME;
    d = f / SLOT;
    s = f % SLOT;
    if (s < BLANK_CYCLES) begin
      e_an = 4'hF;
      e_seg = 8'h00;
    end else begin
      e_an = ~(4'b0001 << d);
      e_seg = exp_seg;
    end
    chk("an", 32'(an), 32'(e_an));
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("frame_start", 32'(frame_start), 32'((f == 0) && (c != 0)));
    chk("dec_nibble", 32'(dec_nibble), 32'(disp[4*d +: 4]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input int ph);
    for (int k = 0; k < FRAME; k++) begin
      if (c % FRAME == ph) break;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    value = '0;
    dp_mask = '0;
    lz_suppress = 1'b0;
    junk = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'h0000_000F);
    chk("rst_seg", 32'(seg_out), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // First frame: zeros shown, frame_start only at cycle 24
    tick();
    tick();
    chk("first_d0_an", 32'(an), 32'h0000_000E);
    chk("first_d0_seg", 32'(seg_out), 32'h7E);
    run_to(0);
    chk("first_fs", 32'(frame_start), 32'h1);

    // Mid-frame load of 12A4 does not tear the current frame
    run_to(10);
    load = 1'b1; value = 16'h12A4; dp_mask = 4'b0100;
    tick();
    load = 1'b0;
    run_to(14);
    chk("no_tear_seg", 32'(seg_out), 32'h7E);
    run_to(2);
    chk("12A4_d0_an", 32'(an), 32'h0000_000E);
    chk("12A4_d0_seg", 32'(seg_out), 32'h33);
    run_to(8);
    chk("12A4_d1_an", 32'(an), 32'h0000_000D);
    chk("12A4_d1_seg", 32'(seg_out), 32'h77);
    run_to(14);
    chk("12A4_d2_an", 32'(an), 32'h0000_000B);
    chk("12A4_d2_seg", 32'(seg_out), 32'hED);
    run_to(20);
    chk("12A4_d3_an", 32'(an), 32'h0000_0007);
    chk("12A4_d3_seg", 32'(seg_out), 32'h30);
    run_to(6);
    chk("gap_an", 32'(an), 32'h0000_000F);
    chk("gap_seg", 32'(seg_out), 32'h00);

    // Leading-zero suppression of 0005
    lz_suppress = 1'b1;
    load = 1'b1; value = 16'h0005; dp_mask = 4'b0000;
    tick();
    load = 1'b0;
    run_to(2);
    chk("lz5_d0_seg", 32'(seg_out), 32'h5B);
    run_to(8);
    chk("lz5_d1_an", 32'(an), 32'h0000_000D);
    chk("lz5_d1_seg", 32'(seg_out), 32'h00);
    run_to(20);
    chk("lz5_d3_an", 32'(an), 32'h0000_0007);
    chk("lz5_d3_seg", 32'(seg_out), 32'h00);

    // All-zero value with suppression; dp survives on a suppressed digit
    load = 1'b1; value = 16'h0000; dp_mask = 4'b0010;
    tick();
    load = 1'b0;
    run_to(2);
    chk("lz0_d0_seg", 32'(seg_out), 32'h7E);
    run_to(8);
    chk("lz0_d1_seg", 32'(seg_out), 32'h80);
    run_to(14);
    chk("lz0_d2_seg", 32'(seg_out), 32'h00);

    // Two loads in one frame: last write wins
    lz_suppress = 1'b0;
    load = 1'b1; value = 16'h1111; dp_mask = 4'b0000;
    tick();
    value = 16'h2222;
    tick();
    load = 1'b0;
    run_to(2);
    chk("last_wins_d0", 32'(seg_out), 32'h6D);
    run_to(20);
    chk("last_wins_d3", 32'(seg_out), 32'h6D);

    // Load on the frame-boundary edge bypasses into the new frame
    run_to(23);
    load = 1'b1; value = 16'h3333;
    tick();
    load = 1'b0;
    chk("bypass_fs", 32'(frame_start), 32'h1);
    run_to(2);
    chk("bypass_d0", 32'(seg_out), 32'h79);
    run_to(8);
    chk("bypass_d1", 32'(seg_out), 32'h79);

    // Asynchronous reset during digit 2 SHOW
    run_to(14);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'h0000_000F);
    chk("arst_seg", 32'(seg_out), 32'h00);
    chk("arst_fs", 32'(frame_start), 32'h0);
    chk("arst_nib", 32'(dec_nibble), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_an", 32'(an), 32'h0000_000F);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    tick();
    tick();
    chk("resume_an", 32'(an), 32'h0000_000E);
    chk("resume_seg", 32'(seg_out), 32'h7E);

    // Random loads, dp masks, suppression toggles and decoder bit 7 noise
    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
      junk = 1'($urandom);
      tick();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
